// File: rtl/controller_rc1_pkg.sv
// Shared definitions for the RC1 control word and the pulse generator FSM.
package controller_rc1_pkg;
  localparam int RC1_CTRL_W    = 25;
  localparam int RC1_EN_BIT    = 24;
  localparam int RC1_WIDTH_MSB = 23;
  localparam int RC1_WIDTH_W   = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rc1_state_t;
endpackage

// File: rtl/controller_rc1_pulse_gen.sv
// Fixed-period, variable-width pulse generator driven by the RC1 control word.
// Width is double-buffered into a shadow that only reloads at period boundaries.
module controller_rc1_pulse_gen
  import controller_rc1_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RC1_CTRL_W-1:0]  ctrl_in,
  output logic                   pwm_out,
  output logic                   period_start,
  output logic                   running,
  output logic [RC1_WIDTH_W-1:0] width_active
);

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(PERIOD_CYCLES - 1);

  rc1_state_t             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   ctrl_en;
  logic [RC1_WIDTH_W-1:0] ctrl_width;

  assign cnt_inc    = cnt_reg + 1'b1;
  assign ctrl_en    = ctrl_in[RC1_EN_BIT];
  assign ctrl_width = ctrl_in[RC1_WIDTH_MSB:0];

  // Outputs are registered: each edge computes what the following cycle shows,
  // so a new period's k=0 values come from the freshly sampled width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      width_active <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      running      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (ctrl_en) begin
            state_reg    <= RUN;
            width_active <= ctrl_width;
            pwm_out      <= (ctrl_width != '0);
            period_start <= 1'b1;
            running      <= 1'b1;
          end else begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            running      <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_reg == LAST_K) begin
            cnt_reg <= '0;
            if (ctrl_en) begin
              width_active <= ctrl_width;
              pwm_out      <= (ctrl_width != '0);
              period_start <= 1'b1;
              running      <= 1'b1;
            end else begin
              // Shadow deliberately keeps its last value for readback.
              state_reg    <= IDLE;
              pwm_out      <= 1'b0;
              period_start <= 1'b0;
              running      <= 1'b0;
            end
          end else begin
            cnt_reg      <= cnt_inc;
            pwm_out      <= (RC1_WIDTH_W'(cnt_inc) < width_active);
            period_start <= 1'b0;
            running      <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          pwm_out      <= 1'b0;
          period_start <= 1'b0;
          running      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_rc1_pulse_gen.sv
// Directed bench for controller_rc1_pulse_gen with a 10-cycle period.
module tb_controller_rc1_pulse_gen;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] ctrl_in = '0;
  logic        pwm_out;
  logic        period_start;
  logic        running;
  logic [23:0] width_active;

  int vectors = 0;
  int miscompares = 0;

  controller_rc1_pulse_gen #(.PERIOD_CYCLES(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrl_in      (ctrl_in),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .running      (running),
    .width_active (width_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int wa);
    check({tag, " pwm"}, 32'(pwm_out), 32'd0);
    check({tag, " pstart"}, 32'(period_start), 32'd0);
    check({tag, " running"}, 32'(running), 32'd0);
    check({tag, " wactive"}, 32'(width_active), 32'(wa));
  endtask

  // One full period with width w; optional ctrl_in writes at k=c1k and k=c2k (-1 = none).
  task automatic period(input string name, input int w,
                        input int c1k, input logic [24:0] c1v,
                        input int c2k, input logic [24:0] c2v);
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      check($sformatf("%s k%0d pwm", name, k), 32'(pwm_out), (k < w) ? 32'd1 : 32'd0);
      check($sformatf("%s k%0d pstart", name, k), 32'(period_start), (k == 0) ? 32'd1 : 32'd0);
      check($sformatf("%s k%0d running", name, k), 32'(running), 32'd1);
      check($sformatf("%s k%0d wactive", name, k), 32'(width_active), 32'(w));
      if (k == c1k) ctrl_in = c1v;
      if (k == c2k) ctrl_in = c2v;
    end
    $display("period %s width=%0d done", name, w);
  endtask

  initial begin
    @(negedge clk);
    check_idle("reset", 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("idle0", 0);
    end

    ctrl_in = 25'h1000003;
    period("start", 3, -1, '0, -1, '0);
    period("start2", 3, 2, 25'h1000007, -1, '0);
    period("buffered", 7, 5, 25'h1000000, -1, '0);
    period("width0", 0, 0, 25'h100000A, -1, '0);
    period("width10a", 10, -1, '0, -1, '0);
    period("width10b", 10, 3, 25'h1FFFFFF, -1, '0);
    period("widthmax_a", 24'hFFFFFF, -1, '0, -1, '0);
    period("widthmax_b", 24'hFFFFFF, 2, 25'h1000005, -1, '0);
    period("glitch", 5, 1, 25'h0000005, 6, 25'h1000005);
    period("after_glitch", 5, 4, 25'h0000005, -1, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_idle("stopped", 5);
    end
    $display("stop: idle with width_active held");

    ctrl_in = 25'h1000005;
    @(negedge clk);
    check("pre_rst k0 pstart", 32'(period_start), 32'd1);
    @(negedge clk);
    check("pre_rst k1 pwm", 32'(pwm_out), 32'd1);
    #2 reset = 1'b1;
    ctrl_in = '0;
    #1;
    check_idle("async_rst", 0);
    $display("async reset at k=1 checked");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("post_rst idle", 0);
    end
    ctrl_in = 25'h1000002;
    period("restart", 2, -1, '0, -1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
